// File: rtl/audio_adc_capture_if.sv
// audio_adc_capture_if: stereo frame stream leaving the capture FIFO.
// The capture block is master; the consumer is slave and owns out_ready.
interface audio_adc_capture_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_left,
    output out_right,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_left,
    input  out_right,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/audio_adc_capture.sv
// audio_adc_capture: WM8731 I2S ADC deserializer feeding a FWFT
// stereo frame FIFO drained over a valid/ready stream.
module audio_adc_capture #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     Reset_n,
  input  logic                     enable,
  input  logic                     AUD_BCLK,
  input  logic                     AUD_ADCLRCK,
  input  logic                     AUD_ADCDAT,
  audio_adc_capture_if.master      aud,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [31:0]              frame_count
);

  localparam int IW = $clog2(DATA_W);
  localparam int CW = IW + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;

  localparam logic [CW-1:0] LP_SLOT_FULL = CW'(DATA_W);
  localparam logic [IW-1:0] LP_MSB       = IW'(DATA_W - 1);
  localparam logic [FW-1:0] LP_DEPTH     = FW'(DEPTH);

  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } arm_state_t;

  logic [1:0]        r_bclk_sync;
  logic [1:0]        r_lrck_sync;
  logic [1:0]        r_dat_sync;
  logic              r_bclk_prev;

  logic              w_bclk_rise;
  logic              w_lrck;
  logic              w_dat;
  logic              w_boundary;
  logic              w_right_done;

  logic              r_lrck_prev;
  logic [DATA_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_left_hold;
  logic [CW-1:0]     r_bit_cnt;
  logic [IW-1:0]     w_bit_idx;

  arm_state_t        r_state;
  arm_state_t        w_state_nxt;
  logic              w_push;

  logic [DATA_W-1:0] r_mem_l [DEPTH];
  logic [DATA_W-1:0] r_mem_r [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [FW-1:0]     r_count;
  logic              r_overflow;
  logic [31:0]       r_frame_cnt;

  logic              w_valid;
  logic              w_pop;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;

  // Bring the codec pins into the clk domain and remember last BCLK.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_bclk_sync <= '0;
      r_lrck_sync <= '0;
      r_dat_sync  <= '0;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_sync <= {r_bclk_sync[0], AUD_BCLK};
      r_lrck_sync <= {r_lrck_sync[0], AUD_ADCLRCK};
      r_dat_sync  <= {r_dat_sync[0], AUD_ADCDAT};
      r_bclk_prev <= r_bclk_sync[1];
    end
  end

  assign w_bclk_rise  = r_bclk_sync[1] & ~r_bclk_prev;
  assign w_lrck       = r_lrck_sync[1];
  assign w_dat        = r_dat_sync[1];
  assign w_boundary   = w_bclk_rise & (w_lrck ^ r_lrck_prev);
  assign w_right_done = w_boundary & ~w_lrck;
  assign w_bit_idx    = LP_MSB - r_bit_cnt[IW-1:0];

  // Shift slot bits MSB-first; a channel change restarts the word
  // and the delay bit on that edge is dropped.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_lrck_prev <= 1'b0;
      r_shreg     <= '0;
      r_left_hold <= '0;
      r_bit_cnt   <= '0;
    end else if (w_bclk_rise) begin
      r_lrck_prev <= w_lrck;
      if (w_boundary) begin
        r_bit_cnt <= '0;
        r_shreg   <= '0;
        if (w_lrck) begin
          r_left_hold <= r_shreg;
        end
      end else if (r_bit_cnt < LP_SLOT_FULL) begin
        r_shreg[w_bit_idx] <= w_dat;
        r_bit_cnt          <= r_bit_cnt + CW'(1);
      end
    end
  end

  // Arming state register.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arm on the first right-word end seen while enabled so the first
  // pushed frame carries a complete left word.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (enable && w_right_done) begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else if (w_right_done) begin
          w_push = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & aud.out_ready;
  assign w_full  = (r_count == LP_DEPTH);
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  // Frame storage; contents only matter behind the pointers.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem_l[r_wptr] <= r_left_hold;
      r_mem_r[r_wptr] <= r_shreg;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case (1'b1)
        (w_wr && !w_pop): r_count <= r_count + FW'(1);
        (w_pop && !w_wr): r_count <= r_count - FW'(1);
        default:          r_count <= r_count;
      endcase
    end
  end

  // Sticky drop flag (a new drop beats the clear) and push counter.
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
      if (w_wr) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
      end
    end
  end

  assign aud.out_valid = w_valid;
  assign aud.out_left  = w_valid ? r_mem_l[r_rptr] : '0;
  assign aud.out_right = w_valid ? r_mem_r[r_rptr] : '0;
  assign overflow      = r_overflow;
  assign fill_level    = r_count;
  assign frame_count   = r_frame_cnt;

endmodule

// File: tb/tb_audio_adc_capture.sv
// tb_audio_adc_capture: I2S stream driver with a frame-level
// reference model and a scoreboard on the output stream.
module tb_audio_adc_capture;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        enable;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic        clr_overflow;
  logic        overflow;
  logic [2:0]  fill_level;
  logic [31:0] frame_count;

  always #5 clk = ~clk;

  audio_adc_capture_if #(.DATA_W(DW)) aif ();

  audio_adc_capture #(
    .DATA_W(DW),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .enable      (enable),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .aud         (aif),
    .overflow    (overflow),
    .clr_overflow(clr_overflow),
    .fill_level  (fill_level),
    .frame_count (frame_count)
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  int          p0;
  logic [31:0] last_pop;
  logic [31:0] exp_f;
  bit          stop_rnd;

  // Reference model state: expected FIFO contents and flags.
  logic [31:0] q[$];
  int          m_fc;
  bit          m_ovf;
  bit          m_armed;
  bit          m_prev;
  bit          m_en;
  logic [15:0] m_done;
  logic [15:0] m_left;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cap(input logic [31:0] w, input int wb);
    logic [31:0] t;
    if (wb >= 16) t = w >> (wb - 16);
    else          t = w << (16 - wb);
    return t[15:0];
  endfunction

  function automatic void model_reset();
    q.delete();
    m_fc    = 0;
    m_ovf   = 1'b0;
    m_armed = 1'b0;
    m_prev  = 1'b0;
  endfunction

  // One sampled BCLK rise with LR level lr.
  function automatic void model_rise(input bit lr, input bit pop_now);
    if (lr != m_prev) begin
      if (lr) begin
        m_left = m_done;
      end else if (m_en) begin
        if (!m_armed) m_armed = 1'b1;
        else if (q.size() >= DEPTH && !pop_now) m_ovf = 1'b1;
        else begin
          q.push_back({m_left, m_done});
          m_fc++;
        end
      end
      m_prev = lr;
    end
  endfunction

  // act: 1 reset pulse, 2 enable off, 3 enable on (during low half)
  task automatic send_bit(input bit lr, input bit d, input bit pop,
                          input int act);
    @(negedge clk);
    AUD_BCLK    = 1'b0;
    AUD_ADCLRCK = lr;
    AUD_ADCDAT  = d;
    case (act)
      1: begin
        repeat (3) @(negedge clk);
        Reset_n = 1'b0;
        repeat (2) @(negedge clk);
        Reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
      end
      2: begin
        enable = 1'b0; m_en = 1'b0; m_armed = 1'b0;
        repeat (7) @(negedge clk);
      end
      3: begin
        enable = 1'b1; m_en = 1'b1;
        repeat (7) @(negedge clk);
      end
      default: repeat (7) @(negedge clk);
    endcase
    AUD_BCLK = 1'b1;
    model_rise(lr, pop);
    if (pop) begin
      @(posedge clk);
      @(posedge clk);
      #1 aif.out_ready = 1'b1;
      @(posedge clk);
      #1 aif.out_ready = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic send_slot(input bit lr, input logic [31:0] w,
                           input int wb, input int slen, input bit pop0,
                           input int act_at, input int act);
    for (int i = 0; i < slen; i++) begin
      bit d;
      d = ($urandom % 2) == 1;
      if (i >= 1 && i <= wb) d = w[wb-i];
      send_bit(lr, d, pop0 && (i == 0), (i == act_at) ? act : 0);
      if (i == 0) m_done = cap(w, wb);
    end
  endtask

  task automatic slot16(input bit lr, input logic [15:0] v);
    send_slot(lr, {16'h0, v}, 16, 32, 1'b0, -1, 0);
  endtask

  task automatic rnd_slot(input bit lr);
    int          wbs[4];
    int          wb;
    int          slen;
    logic [31:0] w;
    wbs  = '{12, 16, 20, 24};
    wb   = wbs[$urandom % 4];
    w    = $urandom & ((32'h1 << wb) - 32'h1);
    slen = (wb < 16) ? wb + 1 : int'($urandom_range(32, wb + 1));
    send_slot(lr, w, wb, slen, 1'b0, -1, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    AUD_BCLK = 1'b0;
    Reset_n  = 1'b0;
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic drain_check(input string tag);
    for (int k = 0; k < 64 && q.size() != 0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_fill"}, fill_level, q.size());
    chk({tag, "_fcnt"}, frame_count, m_fc);
    chk({tag, "_ovf"}, overflow, m_ovf);
  endtask

  // Scoreboard: every accepted frame must be the oldest expected one.
  always @(negedge clk) begin
    if (aif.out_valid === 1'b1 && aif.out_ready === 1'b1) begin
      exp_f = 'x;
      if (q.size() > 0) exp_f = q.pop_front();
      n_pops++;
      last_pop = {aif.out_left, aif.out_right};
      chk("pop_frame", last_pop, exp_f);
    end
  end

  initial begin
    Reset_n       = 1'b0;
    enable        = 1'b0;
    AUD_BCLK      = 1'b0;
    AUD_ADCLRCK   = 1'b0;
    AUD_ADCDAT    = 1'b0;
    clr_overflow  = 1'b0;
    aif.out_ready = 1'b0;
    stop_rnd      = 1'b0;
    m_en          = 1'b0;
    m_done        = '0;
    m_left        = '0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_valid", aif.out_valid, 1'b0);
    chk("rst_fill", fill_level, 3'd0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_fcnt", frame_count, 32'd0);
    chk("rst_left", aif.out_left, 16'd0);
    chk("rst_right", aif.out_right, 16'd0);
    Reset_n = 1'b1;
    model_reset();

    // single frame after arming preamble
    enable = 1'b1; m_en = 1'b1;
    aif.out_ready = 1'b1;
    p0 = n_pops;
    slot16(1'b0, 16'($urandom));
    slot16(1'b1, 16'($urandom));
    slot16(1'b0, 16'h1234);
    slot16(1'b1, 16'hABCD);
    slot16(1'b0, 16'($urandom));
    drain_check("one");
    chk("one_pops", n_pops - p0, 1);
    chk("one_frame", last_pop, 32'h1234ABCD);
    chk("one_fcnt1", frame_count, 32'd1);

    // fill and overflow with consumer stalled
    reset_pulse();
    aif.out_ready = 1'b0;
    slot16(1'b1, 16'($urandom));
    for (int n = 1; n <= 6; n++) begin
      slot16(1'b0, 16'(n));
      slot16(1'b1, ~16'(n));
    end
    slot16(1'b0, 16'd7);
    chk("ovf_fill", fill_level, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_fcnt", frame_count, 32'd4);
    chk("ovf_model_fcnt", frame_count, m_fc);
    chk("ovf_head_l", aif.out_left, 16'd1);
    chk("ovf_head_r", aif.out_right, 16'hFFFE);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    chk("clr_ovf", overflow, 1'b0);

    // push and pop on the same edge while full
    slot16(1'b1, ~16'd7);
    send_slot(1'b0, 32'd8, 16, 32, 1'b1, -1, 0);
    chk("fullpp_fill", fill_level, 3'd4);
    chk("fullpp_ovf", overflow, 1'b0);
    chk("fullpp_fcnt", frame_count, 32'd5);
    aif.out_ready = 1'b1;
    drain_check("fullpp");

    // short 12-bit and long 24-bit slots
    slot16(1'b1, 16'($urandom));
    send_slot(1'b0, 32'hFFF, 12, 13, 1'b0, -1, 0);
    send_slot(1'b1, 32'h89ABCD, 24, 32, 1'b0, -1, 0);
    slot16(1'b0, 16'($urandom));
    drain_check("width");
    chk("width_frame", last_pop, 32'hFFF089AB);

    // random widths with a randomly stalling consumer
    stop_rnd = 1'b0;
    fork
      begin
        while (!stop_rnd) begin
          @(posedge clk);
          #1 aif.out_ready = ($urandom % 2) == 1;
        end
      end
    join_none
    for (int f = 0; f < 12; f++) begin
      rnd_slot(1'b1);
      rnd_slot(1'b0);
    end
    stop_rnd = 1'b1;
    @(posedge clk);
    #2 aif.out_ready = 1'b1;
    drain_check("rand");

    // enable dropped mid right word, re-armed later
    p0 = n_pops;
    send_slot(1'b1, 32'($urandom % 65536), 16, 32, 1'b0, 10, 2);
    send_slot(1'b0, 32'($urandom % 65536), 16, 32, 1'b0, 5, 3);
    slot16(1'b1, 16'($urandom));
    slot16(1'b0, 16'h5A5A);
    slot16(1'b1, 16'hC3C3);
    slot16(1'b0, 16'($urandom));
    drain_check("endrop");
    chk("endrop_pops", n_pops - p0, 1);
    chk("endrop_frame", last_pop, 32'h5A5AC3C3);

    // reset pulse in the middle of a word
    send_slot(1'b1, 32'($urandom % 65536), 16, 32, 1'b0, 9, 1);
    chk("midrst_fcnt", frame_count, 32'd0);
    chk("midrst_fill", fill_level, 3'd0);
    chk("midrst_valid", aif.out_valid, 1'b0);
    p0 = n_pops;
    slot16(1'b0, 16'($urandom));
    slot16(1'b1, 16'($urandom));
    slot16(1'b0, 16'($urandom));
    slot16(1'b1, 16'($urandom));
    slot16(1'b0, 16'($urandom));
    drain_check("midrst");
    chk("midrst_pops", n_pops - p0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
